ahblite_s_arb: RTL and testbench



---
 rtl/ahblite_pkg.sv | 43 ++++
 rtl/ahblite_s_arb_if.sv | 37 +++
 rtl/ahblite_rr_pick.sv | 38 +++
 rtl/ahblite_s_arb.sv | 132 +++++++++++++
 tb/tb_ahblite_s_arb.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ahblite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahblite_pkg
//  Purpose  : AHB-Lite HTRANS/HBURST encodings, arbiter state enum and burst
//             length decode shared by the slave-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package ahblite_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    localparam logic [2:0] c_hburst_single = 3'd0;
    localparam logic [2:0] c_hburst_incr   = 3'd1;
    localparam logic [2:0] c_hburst_wrap4  = 3'd2;
    localparam logic [2:0] c_hburst_incr4  = 3'd3;
    localparam logic [2:0] c_hburst_wrap8  = 3'd4;
    localparam logic [2:0] c_hburst_incr8  = 3'd5;
    localparam logic [2:0] c_hburst_wrap16 = 3'd6;
    localparam logic [2:0] c_hburst_incr16 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARB    = 2'b01,
        ST_ACCESS = 2'b10
    } arb_state_t;

    // Undefined-length INCR is arbitrated one beat at a time.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        case (hburst)
            c_hburst_wrap4,  c_hburst_incr4:  len = 5'd4;
            c_hburst_wrap8,  c_hburst_incr8:  len = 5'd8;
            c_hburst_wrap16, c_hburst_incr16: len = 5'd16;
            default:                          len = 5'd1;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahblite_s_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahblite_s_arb_if
//  Purpose  : Request/attribute inputs and grant/select outputs of one
//             AHB-Lite slave-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface ahblite_s_arb_if #(
    parameter int MST_NUM  = 4,
    parameter int WEIGHT_W = 4,
    parameter int MID_W    = $clog2(MST_NUM)
);
    logic [MST_NUM-1:0]               req_i;
    logic [MST_NUM-1:0][1:0]          htrans_i;
    logic [MST_NUM-1:0][2:0]          hburst_i;
    logic [MST_NUM-1:0]               hmastlock_i;
    logic [MST_NUM-1:0][WEIGHT_W-1:0] weight_i;
    logic                             hreadyout_i;
    logic [MST_NUM-1:0]               grant_o;
    logic [MID_W-1:0]                 cur_mst_o;
    logic                             hsel_o;
    logic                             busy_o;
    logic [4:0]                       beat_cnt_o;

    // Arbiter view.
    modport slave (
        input  req_i, htrans_i, hburst_i, hmastlock_i, weight_i, hreadyout_i,
        output grant_o, cur_mst_o, hsel_o, busy_o, beat_cnt_o
    );

    // Request-source view.
    modport master (
        output req_i, htrans_i, hburst_i, hmastlock_i, weight_i, hreadyout_i,
        input  grant_o, cur_mst_o, hsel_o, busy_o, beat_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/ahblite_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : ahblite_rr_pick
//  Purpose  : Combinational round-robin picker: first requester after ptr,
//             wrapping, with ptr itself considered last.
//  Revision : 1.0  initial release
// ============================================================================
module ahblite_rr_pick #(
    parameter int MST_NUM = 4,
    parameter int MID_W   = $clog2(MST_NUM)
) (
    input  wire logic [MST_NUM-1:0] req,
    input  wire logic [MID_W-1:0]   ptr,
    output logic      [MID_W-1:0]   idx,
    output logic                    valid
);

    int w_best;
    int w_dist;

    // Distance 0 is ptr+1, distance MST_NUM-1 is ptr itself.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        w_best = MST_NUM;
        w_dist = 0;
        for (int i = 0; i < MST_NUM; i++) begin
            w_dist = (i + 2 * MST_NUM - int'(ptr) - 1) % MST_NUM;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = MID_W'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahblite_s_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ahblite_s_arb
//  Purpose  : Burst-aware weighted round-robin arbiter for one AHB-Lite slave
//             port. Optional AHBLITE_ARB_LOCK_EN keeps locked owners.
//  Revision : 1.0  initial release
// ============================================================================
module ahblite_s_arb
    import ahblite_pkg::*;
#(
    parameter int MST_NUM  = 4,
    parameter int WEIGHT_W = 4,
    parameter int MID_W    = $clog2(MST_NUM)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    ahblite_s_arb_if.slave bus
);

    arb_state_t        r_state,    w_state_nxt;
    logic [MID_W-1:0]  r_cur_mst,  w_cur_mst_nxt;
    logic [WEIGHT_W-1:0] r_credit, w_credit_nxt;
    logic [4:0]        r_beat_cnt, w_beat_cnt_nxt;
    logic [4:0]        r_len,      w_len_nxt;

    logic [MID_W-1:0]    w_pick_idx;
    logic                w_pick_vld;
    logic [WEIGHT_W-1:0] w_weight_sel;
    logic [WEIGHT_W-1:0] w_credit_load;
    logic [1:0]          w_own_trans;
    logic                w_beat_acc;
    logic                w_nonseq_acc;
    logic [4:0]          w_eff_len;
    logic                w_burst_end;
    logic                w_lock_hold;

    ahblite_rr_pick #(
        .MST_NUM (MST_NUM),
        .MID_W   (MID_W)
    ) u_pick (
        .req   (bus.req_i),
        .ptr   (r_cur_mst),
        .idx   (w_pick_idx),
        .valid (w_pick_vld)
    );

    assign w_weight_sel  = bus.weight_i[w_pick_idx];
    assign w_credit_load = (w_weight_sel == '0) ? WEIGHT_W'(1) : w_weight_sel;

    assign w_own_trans  = bus.htrans_i[r_cur_mst];
    assign w_beat_acc   = (r_state == ST_ACCESS) && bus.hreadyout_i && w_own_trans[1];
    assign w_nonseq_acc = w_beat_acc && (w_own_trans == c_htrans_nonseq);
    // The first beat of a burst must see its own length, not the stale one.
    assign w_eff_len    = w_nonseq_acc ? burst_len(bus.hburst_i[r_cur_mst]) : r_len;
    assign w_burst_end  = w_beat_acc && ((r_beat_cnt + 5'd1) == w_eff_len);

`ifdef AHBLITE_ARB_LOCK_EN
    assign w_lock_hold = bus.hmastlock_i[r_cur_mst] && bus.req_i[r_cur_mst];
`else
    logic w_lock_unused;
    assign w_lock_hold   = 1'b0;
    assign w_lock_unused = ^bus.hmastlock_i;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_mst_nxt  = r_cur_mst;
        w_credit_nxt   = r_credit;
        w_beat_cnt_nxt = r_beat_cnt;
        w_len_nxt      = r_len;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                w_state_nxt = ST_ACCESS;
                if (bus.req_i[r_cur_mst] && (r_credit > WEIGHT_W'(1))) begin
                    w_credit_nxt = r_credit - WEIGHT_W'(1);
                end else if (w_pick_vld) begin
                    w_cur_mst_nxt = w_pick_idx;
                    w_credit_nxt  = w_credit_load;
                end
            end
            ST_ACCESS: begin
                if (w_nonseq_acc) begin
                    w_len_nxt = w_eff_len;
                end
                if (w_burst_end) begin
                    w_beat_cnt_nxt = 5'd0;
                    if (w_lock_hold) begin
                        w_state_nxt = ST_ACCESS;
                    end else if (|bus.req_i) begin
                        w_state_nxt = ST_ARB;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_beat_acc) begin
                    w_beat_cnt_nxt = r_beat_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cur_mst  <= MID_W'(MST_NUM - 1);
            r_credit   <= '0;
            r_beat_cnt <= 5'd0;
            r_len      <= 5'd1;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_mst  <= w_cur_mst_nxt;
            r_credit   <= w_credit_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_len      <= w_len_nxt;
        end
    end

    assign bus.grant_o    = (r_state == ST_ACCESS) ? (MST_NUM'(1) << r_cur_mst) : '0;
    assign bus.cur_mst_o  = r_cur_mst;
    assign bus.hsel_o     = (r_state == ST_ARB) || (r_state == ST_ACCESS);
    assign bus.busy_o     = (r_state == ST_ACCESS);
    assign bus.beat_cnt_o = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ahblite_s_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahblite_s_arb
//  Purpose  : Directed self-checking bench for the slave-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahblite_s_arb;
    import ahblite_pkg::*;

    localparam int MST_NUM  = 4;
    localparam int WEIGHT_W = 4;
    localparam int MID_W    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    ahblite_s_arb_if #(.MST_NUM(MST_NUM), .WEIGHT_W(WEIGHT_W), .MID_W(MID_W)) bus ();

    ahblite_s_arb #(.MST_NUM(MST_NUM), .WEIGHT_W(WEIGHT_W), .MID_W(MID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_i       = '0;
        bus.htrans_i    = '0;
        bus.hburst_i    = '0;
        bus.hmastlock_i = '0;
        for (int i = 0; i < MST_NUM; i++) bus.weight_i[i] = 4'd1;
        bus.hreadyout_i = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, bus.grant_o,    32'd0);
        chk({tag, "_cur"},   bus.cur_mst_o,  32'd3);
        chk({tag, "_hsel"},  bus.hsel_o,     32'd0);
        chk({tag, "_busy"},  bus.busy_o,     32'd0);
        chk({tag, "_beat"},  bus.beat_cnt_o, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 1'b0;
        step();
        chk_reset(tag);
        rst_n = 1'b1;
    endtask

    // Expect one ARB bubble cycle, then advance into ACCESS.
    task automatic arb_bubble();
        chk("bubble_grant", bus.grant_o, 32'd0);
        chk("bubble_hsel",  bus.hsel_o,  32'd1);
        chk("bubble_busy",  bus.busy_o,  32'd0);
        step();
    endtask

    // Owner m performs an n-beat burst; stall bit k drops HREADYOUT in cycle k.
    task automatic burst(input int m, input logic [2:0] hb, input int n, input logic [15:0] stall);
        int acc;
        int cyc;
        logic [15:0] s;
        acc = 0;
        cyc = 0;
        s   = stall;
        chk("burst_grant", bus.grant_o, 32'd1 << m);
        chk("burst_owner", bus.cur_mst_o, m);
        chk("burst_busy",  bus.busy_o, 32'd1);
        bus.hburst_i[m] = hb;
        while (acc < n && cyc < 40) begin
            bus.htrans_i[m] = (acc == 0) ? c_htrans_nonseq : c_htrans_seq;
            bus.hreadyout_i = ~s[0];
            step();
            if (!s[0]) acc++;
            s = s >> 1;
            cyc++;
            chk("beat_cnt", bus.beat_cnt_o, acc % n);
            if (acc < n) chk("burst_hold", bus.grant_o, 32'd1 << m);
        end
        bus.htrans_i[m] = c_htrans_idle;
        bus.hreadyout_i = 1'b1;
        chk("burst_beats", acc, n);
    endtask

    initial begin
        int ord[5];
        int pat[8];
        ord = '{0, 1, 2, 3, 0};
        pat = '{0, 0, 0, 1, 0, 0, 0, 1};

        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk_reset("rst");
        rst_n = 1'b1;

        // Single master, SINGLE transfer
        bus.req_i       = 4'b0001;
        bus.hburst_i[0] = c_hburst_single;
        bus.htrans_i[0] = c_htrans_nonseq;
        step();
        chk("t1_arb_grant", bus.grant_o, 32'd0);
        chk("t1_arb_hsel",  bus.hsel_o,  32'd1);
        step();
        chk("t1_grant", bus.grant_o,   32'b0001);
        chk("t1_busy",  bus.busy_o,    32'd1);
        chk("t1_cur",   bus.cur_mst_o, 32'd0);
        bus.req_i = '0;
        step();
        chk("t1_idle_hsel",  bus.hsel_o,     32'd0);
        chk("t1_idle_grant", bus.grant_o,    32'd0);
        chk("t1_idle_beat",  bus.beat_cnt_o, 32'd0);
        chk("t1_idle_cur",   bus.cur_mst_o,  32'd0);
        bus.htrans_i[0] = c_htrans_idle;
        step();
        chk("t1_stay_idle", bus.hsel_o, 32'd0);

        // Fairness: all masters INCR4, weight 1
        do_reset("rst_fair");
        bus.req_i = 4'b1111;
        step();
        arb_bubble();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.req_i = '0;
            burst(ord[i], c_hburst_incr4, 4, 16'h0000);
            if (i < 4) arb_bubble();
        end
        chk("fair_idle", bus.hsel_o, 32'd0);

        // Weights: master 0 weight 3, master 1 weight 0 (acts as 1)
        do_reset("rst_wt");
        bus.weight_i[0] = 4'd3;
        bus.weight_i[1] = 4'd0;
        bus.req_i       = 4'b0011;
        step();
        arb_bubble();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) bus.req_i = '0;
            burst(pat[i], c_hburst_single, 1, 16'h0000);
            if (i < 7) arb_bubble();
        end
        chk("wt_idle", bus.hsel_o, 32'd0);

        // Wait states on beats 3 and 6 of INCR8
        do_reset("rst_ws");
        bus.req_i = 4'b0100;
        step();
        arb_bubble();
        bus.req_i = '0;
        burst(2, c_hburst_incr8, 8, 16'h0044);
        chk("ws_idle", bus.hsel_o, 32'd0);

        // Reset in the middle of a WRAP16
        do_reset("rst_mid0");
        bus.req_i       = 4'b0010;
        bus.hburst_i[1] = c_hburst_wrap16;
        step();
        arb_bubble();
        chk("mid_grant", bus.grant_o, 32'b0010);
        bus.htrans_i[1] = c_htrans_nonseq;
        step();
        chk("mid_beat1", bus.beat_cnt_o, 32'd1);
        bus.htrans_i[1] = c_htrans_seq;
        step();
        chk("mid_beat2", bus.beat_cnt_o, 32'd2);
        rst_n = 1'b0;
        step();
        chk_reset("mid_rst");
        rst_n = 1'b1;
        clear_inputs();

        // Locked master 2 against requesting master 3
        do_reset("rst_lock");
        bus.req_i          = 4'b1100;
        bus.hmastlock_i[2] = 1'b1;
        step();
        arb_bubble();
        burst(2, c_hburst_incr4, 4, 16'h0000);
`ifdef AHBLITE_ARB_LOCK_EN
        bus.hmastlock_i[2] = 1'b0;
        bus.req_i          = 4'b1000;
        burst(2, c_hburst_incr4, 4, 16'h0000);
`endif
        arb_bubble();
        bus.req_i       = '0;
        bus.hmastlock_i = '0;
        burst(3, c_hburst_incr4, 4, 16'h0000);
        chk("lock_idle", bus.hsel_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
